// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared opcode, register and state definitions for the RV64 pipeline
`timescale 1ns/1ps
package rv_pipe_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_t;

    // Instruction formats that read rs1: R, I-load, I-alu, S, B
    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_LOAD, OP_ADDI, OP_STORE, OP_BRANCH: uses_rs1 = 1'b1;
            default:                                         uses_rs1 = 1'b0;
        endcase
    endfunction

    // Instruction formats that read rs2: R, S, B
    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            default:                       uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// rtl/hazard_controller_sat_counter.sv - saturating event counter
`timescale 1ns/1ps
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use / branch / memory-freeze sequencing for the 5-stage pipeline
`timescale 1ns/1ps
module hazard_controller
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       IFID_Opcode,
    input  logic [4:0]       IFID_Rs1,
    input  logic [4:0]       IFID_Rs2,
    input  logic [4:0]       IDEX_Rd,
    input  logic             IDEX_MemRead,
    input  logic             Branch_Taken,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemWrite,
    input  logic             DMem_Ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             MEMWB_Bubble,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count,
    output logic             Mem_Error
);

    localparam logic [TO_W-1:0] WAIT_MAX  = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    pipe_state_t     state, state_next;
    logic [TO_W-1:0] wait_cnt;
    logic            mem_busy;
    logic            load_use;
    logic            waiting;
    logic            stall_inc;
    logic            flush_inc;

    assign mem_busy = (EXMEM_MemRead | EXMEM_MemWrite) & ~DMem_Ready;
    assign load_use = IDEX_MemRead && (IDEX_Rd != REG_X0) &&
                      ((uses_rs1(IFID_Opcode) && (IDEX_Rd == IFID_Rs1)) ||
                       (uses_rs2(IFID_Opcode) && (IDEX_Rd == IFID_Rs2)));
    assign waiting  = (state == MEM_WAIT) && !DMem_Ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // Enter the freeze on an unfinished access, leave it the cycle memory answers
    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (mem_busy)   state_next = MEM_WAIT;
            MEM_WAIT: if (DMem_Ready) state_next = RUN;
            default:                  state_next = RUN;
        endcase
    end

    // Stage enables and bubbles: memory freeze beats branch flush beats load-use stall
    always_comb begin
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        EXMEMWrite   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Bubble  = 1'b0;
        MEMWB_Bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!reset) begin
            // hold the defaults while in reset
        end else if (mem_busy) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEMWrite   = 1'b0;
            MEMWB_Bubble = 1'b1;
            stall_inc    = 1'b1;
        end else if (Branch_Taken) begin
            IFID_Flush   = 1'b1;
            IDEX_Bubble  = 1'b1;
            flush_inc    = 1'b1;
        end else if (load_use) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEX_Bubble  = 1'b1;
            stall_inc    = 1'b1;
        end
    end

    // Count consecutive wait cycles, holding at the timeout value
    always_ff @(posedge clk) begin
        if (!reset || !waiting) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky error raised on the edge the wait counter reaches the timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            Mem_Error <= 1'b0;
        end else if (waiting && ((wait_cnt == WAIT_LAST) || (wait_cnt == WAIT_MAX))) begin
            Mem_Error <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (Flush_Count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
`timescale 1ns/1ps
module tb_hazard_controller;
    import rv_pipe_pkg::*;

    localparam logic [6:0] C_NORMAL = 7'b1111_000;
    localparam logic [6:0] C_LDUSE  = 7'b0011_010;
    localparam logic [6:0] C_BRANCH = 7'b1111_110;
    localparam logic [6:0] C_FREEZE = 7'b0000_001;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic        clk;
    logic        reset;
    logic [6:0]  IFID_Opcode;
    logic [4:0]  IFID_Rs1;
    logic [4:0]  IFID_Rs2;
    logic [4:0]  IDEX_Rd;
    logic        IDEX_MemRead;
    logic        Branch_Taken;
    logic        EXMEM_MemRead;
    logic        EXMEM_MemWrite;
    logic        DMem_Ready;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IDEXWrite;
    logic        EXMEMWrite;
    logic        IFID_Flush;
    logic        IDEX_Bubble;
    logic        MEMWB_Bubble;
    logic [31:0] Stall_Count;
    logic [31:0] Flush_Count;
    logic        Mem_Error;
    logic [6:0]  ctrl;

    logic        sat_reset;
    logic        sat_inc;
    logic [1:0]  sat_count;

    int n_pass  = 0;
    int n_total = 0;

    hazard_controller #(.CNT_W(32), .MEM_TIMEOUT(4), .TO_W(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .IFID_Opcode    (IFID_Opcode),
        .IFID_Rs1       (IFID_Rs1),
        .IFID_Rs2       (IFID_Rs2),
        .IDEX_Rd        (IDEX_Rd),
        .IDEX_MemRead   (IDEX_MemRead),
        .Branch_Taken   (Branch_Taken),
        .EXMEM_MemRead  (EXMEM_MemRead),
        .EXMEM_MemWrite (EXMEM_MemWrite),
        .DMem_Ready     (DMem_Ready),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IDEXWrite      (IDEXWrite),
        .EXMEMWrite     (EXMEMWrite),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Bubble    (IDEX_Bubble),
        .MEMWB_Bubble   (MEMWB_Bubble),
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count),
        .Mem_Error      (Mem_Error)
    );

    sat_counter #(.W(2)) u_sat (
        .clk   (clk),
        .reset (sat_reset),
        .inc   (sat_inc),
        .count (sat_count)
    );

    assign ctrl = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFID_Flush, IDEX_Bubble, MEMWB_Bubble};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IFID_Opcode    = 7'd0;
        IFID_Rs1       = 5'd0;
        IFID_Rs2       = 5'd0;
        IDEX_Rd        = 5'd0;
        IDEX_MemRead   = 1'b0;
        Branch_Taken   = 1'b0;
        EXMEM_MemRead  = 1'b0;
        EXMEM_MemWrite = 1'b0;
        DMem_Ready     = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic drive_lu(input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
        IFID_Opcode  = op;
        IDEX_Rd      = rd;
        IFID_Rs1     = rs1;
        IFID_Rs2     = rs2;
        IDEX_MemRead = 1'b1;
    endtask

    initial begin
        idle();
        reset     = 1'b0;
        sat_reset = 1'b0;
        sat_inc   = 1'b0;

        // reset overrides a freeze request and a load-use
        EXMEM_MemWrite = 1'b1;
        DMem_Ready     = 1'b0;
        drive_lu(OP_RTYPE, 5'd5, 5'd5, 5'd0);
        #1;
        check("rst_ctrl", ctrl, C_NORMAL);
        step();
        check("rst_stall", Stall_Count, 0);
        check("rst_flush", Flush_Count, 0);
        check("rst_err", Mem_Error, 0);
        check("rst_state", dut.state, RUN);
        idle();
        reset = 1'b1;
        #1;
        check("idle_ctrl", ctrl, C_NORMAL);

        // load-use through rs1 lasts one cycle
        drive_lu(OP_RTYPE, 5'd5, 5'd5, 5'd7);
        #1;
        check("lu_rs1", ctrl, C_LDUSE);
        step();
        idle();
        #1;
        check("lu_release", ctrl, C_NORMAL);
        check("lu_stall1", Stall_Count, 1);
        step();
        check("lu_stall1b", Stall_Count, 1);

        // rs2 dependency on an R-type
        drive_lu(OP_RTYPE, 5'd5, 5'd3, 5'd5);
        #1;
        check("lu_rs2", ctrl, C_LDUSE);
        step();
        check("lu_stall2", Stall_Count, 2);

        // x0 destination never stalls
        drive_lu(OP_RTYPE, 5'd0, 5'd0, 5'd0);
        #1;
        check("lu_x0", ctrl, C_NORMAL);

        // addi does not read rs2
        drive_lu(OP_ADDI, 5'd5, 5'd3, 5'd5);
        #1;
        check("lu_addi_rs2", ctrl, C_NORMAL);
        step();
        check("lu_stall_keep", Stall_Count, 2);

        // store reads rs2
        drive_lu(OP_STORE, 5'd5, 5'd3, 5'd5);
        #1;
        check("lu_store_rs2", ctrl, C_LDUSE);
        step();

        // jal reads neither source
        drive_lu(OP_JAL, 5'd5, 5'd5, 5'd5);
        #1;
        check("lu_jal", ctrl, C_NORMAL);
        step();
        check("lu_stall3", Stall_Count, 3);

        // taken branch wins over load-use
        do_reset();
        drive_lu(OP_RTYPE, 5'd5, 5'd5, 5'd0);
        Branch_Taken = 1'b1;
        #1;
        check("br_over_lu", ctrl, C_BRANCH);
        step();
        check("br_flush1", Flush_Count, 1);
        check("br_stall0", Stall_Count, 0);
        IDEX_MemRead = 1'b0;
        #1;
        check("br_alone", ctrl, C_BRANCH);
        step();
        check("br_flush2", Flush_Count, 2);

        // store waits 3 cycles; branch and load-use deferred during freeze
        do_reset();
        EXMEM_MemWrite = 1'b1;
        DMem_Ready     = 1'b0;
        Branch_Taken   = 1'b1;
        drive_lu(OP_RTYPE, 5'd5, 5'd5, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("frz_%0d", i), ctrl, C_FREEZE);
            step();
        end
        check("frz_state", dut.state, MEM_WAIT);
        DMem_Ready = 1'b1;
        #1;
        check("frz_release", ctrl, C_BRANCH);
        step();
        check("frz_stall", Stall_Count, 3);
        check("frz_flush", Flush_Count, 1);
        check("frz_state_run", dut.state, RUN);

        // zero-wait access in RUN
        idle();
        EXMEM_MemRead = 1'b1;
        #1;
        check("zw_ctrl", ctrl, C_NORMAL);
        step();
        check("zw_stall", Stall_Count, 3);
        check("zw_state", dut.state, RUN);

        // timeout after 4 cycles in MEM_WAIT
        do_reset();
        EXMEM_MemRead = 1'b1;
        DMem_Ready    = 1'b0;
        step();
        repeat (3) step();
        check("to_err_early", Mem_Error, 0);
        step();
        check("to_err_set", Mem_Error, 1);
        check("to_freeze", ctrl, C_FREEZE);
        check("to_stall", Stall_Count, 5);
        step();
        check("to_err_sticky", Mem_Error, 1);
        check("to_wait_hold", dut.wait_cnt, 4);
        reset = 1'b0;
        #1;
        check("to_rst_ctrl", ctrl, C_NORMAL);
        step();
        reset = 1'b1;
        idle();
        #1;
        check("to_rst_err", Mem_Error, 0);
        check("to_rst_stall", Stall_Count, 0);
        check("to_rst_state", dut.state, RUN);
        check("to_rst_wait", dut.wait_cnt, 0);

        // counter saturation at all-ones
        sat_reset = 1'b0;
        step();
        sat_reset = 1'b1;
        sat_inc   = 1'b1;
        repeat (3) step();
        check("sat_full", sat_count, 3);
        repeat (2) step();
        check("sat_hold", sat_count, 3);
        sat_inc = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage RV64 datapath (IF/ID/EX/MEM/WB).
- Detects load-use hazards and taken branches, and freezes the pipeline while a data-memory access is outstanding.
- Drives the per-stage write enables, flushes and the ID/EX control-bubble select; the ID/EX bubble zeroes all Control_Unit outputs.
- Keeps saturating stall and flush counters and a sticky memory-timeout error flag.

Parameters:
- CNT_W, 32, width of the performance counters.
- MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before the error flag is set.
- TO_W, 7, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- IFID_Opcode  in  7  opcode of the instruction in ID.
- IFID_Rs1  in  5  rs1 field of the instruction in ID.
- IFID_Rs2  in  5  rs2 field of the instruction in ID.
- IDEX_Rd  in  5  rd of the instruction in EX.
- IDEX_MemRead  in  1  instruction in EX is a load.
- Branch_Taken  in  1  branch in EX resolved as taken this cycle.
- EXMEM_MemRead  in  1  load in MEM.
- EXMEM_MemWrite  in  1  store in MEM.
- DMem_Ready  in  1  data memory completes the MEM-stage access this cycle.
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEXWrite  out  1  ID/EX register enable.
- EXMEMWrite  out  1  EX/MEM register enable.
- IFID_Flush  out  1  IF/ID register loads a NOP.
- IDEX_Bubble  out  1  ID/EX register loads zeroed control signals.
- MEMWB_Bubble  out  1  MEM/WB register loads zeroed control signals.
- Stall_Count  out  CNT_W  stall cycles since reset.
- Flush_Count  out  CNT_W  taken-branch flushes since reset.
- Mem_Error  out  1  sticky memory-timeout flag.

Behaviour:
- State register has two states, RUN and MEM_WAIT. State, counters and Mem_Error are registered. Enables, flushes and bubbles are combinational from state and inputs.
- Reset (reset==0 at a clock edge), regardless of state or pending wait:
  - state goes to RUN; wait counter, Stall_Count, Flush_Count and Mem_Error go to 0.
  - While reset is low, all enables are 1 and all flush/bubble outputs are 0.
- Derived signals:
  - mem_access = EXMEM_MemRead | EXMEM_MemWrite.
  - mem_busy = mem_access & ~DMem_Ready.
  - uses_rs1 is true for opcodes 0110011, 0000011, 0010011, 0100011, 1100011.
  - uses_rs2 is true for opcodes 0110011, 0100011, 1100011.
  - load_use = IDEX_MemRead & (IDEX_Rd != 0) & ((uses_rs1 & IDEX_Rd == IFID_Rs1) | (uses_rs2 & IDEX_Rd == IFID_Rs2)).
- Output priority, highest first:
  - 1. mem_busy in either state: all four enables = 0, MEMWB_Bubble = 1, IFID_Flush = 0, IDEX_Bubble = 0. Branch and load-use handling is deferred until the freeze releases.
  - 2. Branch_Taken: PCWrite = 1 (target loaded), IFID_Flush = 1, IDEX_Bubble = 1. A coincident load_use is discarded because the younger instruction is squashed.
  - 3. load_use: PCWrite = 0, IFIDWrite = 0, IDEX_Bubble = 1; the other enables stay 1. This lasts exactly one cycle, because the next cycle sees IDEX_MemRead = 0.
  - 4. Otherwise all enables are 1 and all flushes/bubbles are 0.
- Transitions:
  - RUN to MEM_WAIT when mem_busy.
  - MEM_WAIT to RUN in the cycle DMem_Ready = 1; that release cycle runs normal priority 2–4 decode.
  - The access completes the same cycle DMem_Ready rises (zero-wait when already high in RUN).
- Wait counter:
  - Increments each cycle in MEM_WAIT and clears on the transition to RUN.
  - When it reaches MEM_TIMEOUT, Mem_Error is set (sticky until reset); the counter holds at MEM_TIMEOUT and the freeze continues.
- Counters (saturate at all-ones, no wrap):
  - Stall_Count increments in every cycle where priority 1 or priority 3 applies.
  - Flush_Count increments in every cycle where priority 2 applies.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - opcode constants OP_RTYPE = 0110011, OP_LOAD = 0000011, OP_ADDI = 0010011, OP_STORE = 0100011, OP_BRANCH = 1100011;
  - the state encoding RUN/MEM_WAIT;
  - the zero-x0 register constant.
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated twice for the performance counters.

Test Plan:
- ld x5 in EX (IDEX_MemRead = 1, IDEX_Rd = 5); add with Rs1 = 5 in ID → exactly 1 cycle of PCWrite = 0, IFIDWrite = 0, IDEX_Bubble = 1; Stall_Count = 1.
- IDEX_Rd = 0, IDEX_MemRead = 1, Rs1 = 0; also addi (Rs2 field = 5) behind ld x5 → no stall in either case.
- Branch_Taken = 1 together with load_use → IFID_Flush = 1, IDEX_Bubble = 1, PCWrite = 1, no stall; Flush_Count = 1, Stall_Count = 0.
- Store in MEM with DMem_Ready low for 3 cycles then high → 3 frozen cycles with MEMWB_Bubble = 1, release on the 4th cycle; Stall_Count = 3; state returns to RUN.
- MEM_TIMEOUT = 4, DMem_Ready held low → Mem_Error = 1 after 4 cycles in MEM_WAIT while the freeze persists; reset low for 1 edge mid-wait → RUN, all counters 0, Mem_Error = 0.
